// File: rtl/shift_sub_three_if.sv
// Request/result bundle for the BCD-to-binary converter.
// The master drives the digits and start, and the slave returns the result and status.
interface shift_sub_three_if;
  logic       start;
  logic [3:0] tens;
  logic [3:0] units;
  logic [6:0] number;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output start, tens, units,
    input  number, busy, done, err
  );

  modport slave (
    input  start, tens, units,
    output number, busy, done, err
  );
endinterface

// File: rtl/shift_sub_three.sv
// Two-digit BCD to 7-bit binary converter using reverse double-dabble.
// Each step shifts right and then subtracts 3 from each BCD nibble that is 8 or more.
module shift_sub_three (
  input  logic             clk,
  input  logic             rst,
  shift_sub_three_if.slave bus
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state_q, state_d;
  logic [14:0] work_q, work_d;
  logic [2:0]  count_q, count_d;
  logic [6:0]  number_q, number_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [14:0] stepped;
  logic        digitsBad;

  // The two nibbles are corrected independently, so no borrow passes between the tens and units digits.
  function automatic logic [14:0] shiftStep(input logic [14:0] w);
    logic [14:0] s;
    s = w >> 1;
    if (s[14:11] >= 4'd8) s[14:11] = s[14:11] - 4'd3;
    if (s[10:7]  >= 4'd8) s[10:7]  = s[10:7]  - 4'd3;
    return s;
  endfunction

  assign stepped   = shiftStep(work_q);
  assign digitsBad = (bus.tens > 4'd9) || (bus.units > 4'd9);

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    count_d  = count_q;
    number_d = number_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (digitsBad) begin
            number_d = 7'd0;
            err_d    = 1'b1;
            done_d   = 1'b1;
          end else begin
            work_d  = {bus.tens, bus.units, 7'b0};
            count_d = 3'd0;
            busy_d  = 1'b1;
            err_d   = 1'b0;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        work_d  = stepped;
        count_d = count_q + 3'd1;
        // Step seven is the last one; the binary result now sits in the low seven bits.
        if (count_q == 3'd6) begin
          number_d = stepped[6:0];
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      work_q   <= 15'd0;
      count_q  <= 3'd0;
      number_q <= 7'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      count_q  <= count_d;
      number_q <= number_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus.number = number_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_shift_sub_three.sv
// Bench for shift_sub_three: directed vectors, an arithmetic reference model,
// and a per-cycle compare of all outputs against that model.
module tb_shift_sub_three;

  logic clk;
  logic rst;
  shift_sub_three_if bus ();

  shift_sub_three dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit checkEn = 1'b0;

  // Reference model: a conversion is a countdown of 7 edges that ends by publishing 10*tens+units.
  int       modelRemaining = 0;
  int       modelPending   = 0;
  int       modelNumber    = 0;
  bit       modelBusy      = 1'b0;
  bit       modelDone      = 1'b0;
  bit       modelErr       = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      modelRemaining = 0;
      modelNumber    = 0;
      modelBusy      = 1'b0;
      modelDone      = 1'b0;
      modelErr       = 1'b0;
    end else begin
      modelDone = 1'b0;
      if (modelRemaining > 0) begin
        modelRemaining = modelRemaining - 1;
        if (modelRemaining == 0) begin
          modelNumber = modelPending;
          modelDone   = 1'b1;
          modelBusy   = 1'b0;
        end
      end else if (bus.start) begin
        if (bus.tens > 9 || bus.units > 9) begin
          modelNumber = 0;
          modelErr    = 1'b1;
          modelDone   = 1'b1;
        end else begin
          modelPending   = 10 * int'(bus.tens) + int'(bus.units);
          modelRemaining = 7;
          modelBusy      = 1'b1;
          modelErr       = 1'b0;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks = checks + 1;
    if (actual != expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("cyc_number", int'(bus.number), modelNumber);
      checkOutput("cyc_busy",   int'(bus.busy),   int'(modelBusy));
      checkOutput("cyc_done",   int'(bus.done),   int'(modelDone));
      checkOutput("cyc_err",    int'(bus.err),    int'(modelErr));
    end
  end

  // Presents digits with start for exactly one rising edge, then scrambles the digits.
  task automatic applyStimulus(input logic [3:0] t, input logic [3:0] u);
    bus.start = 1'b1;
    bus.tens  = t;
    bus.units = u;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.tens  = ~t;
    bus.units = ~u;
  endtask

  // Counts falling edges after the accepting edge until done is seen: 8 for valid, 1 for invalid.
  task automatic waitDone(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (bus.done) begin
        cyc = i;
        return;
      end
    end
    checks = checks + 1;
    errors = errors + 1;
    $display("[TB] FAIL done_timeout actual=none expected=pulse at %0t", $time);
  endtask

  int cyc;
  int pulses;

  initial begin
    bus.start = 1'b0;
    bus.tens  = 4'd0;
    bus.units = 4'd0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_number", int'(bus.number), 0);
    checkOutput("reset_busy",   int'(bus.busy),   0);
    checkOutput("reset_done",   int'(bus.done),   0);
    checkOutput("reset_err",    int'(bus.err),    0);
    checkEn = 1'b1;
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(4'd9, 4'd9);
    waitDone(cyc);
    checkOutput("lat_99", cyc, 8);
    checkOutput("num_99", int'(bus.number), 99);
    checkOutput("err_99", int'(bus.err), 0);

    applyStimulus(4'd4, 4'd2);
    waitDone(cyc);
    checkOutput("num_42", int'(bus.number), 42);
    applyStimulus(4'd0, 4'd0);
    waitDone(cyc);
    checkOutput("lat_b2b", cyc, 8);
    checkOutput("num_00", int'(bus.number), 0);

    applyStimulus(4'hA, 4'd3);
    waitDone(cyc);
    checkOutput("lat_bad", cyc, 1);
    checkOutput("err_bad", int'(bus.err), 1);
    checkOutput("num_bad", int'(bus.number), 0);
    checkOutput("busy_bad", int'(bus.busy), 0);
    applyStimulus(4'd1, 4'd2);
    waitDone(cyc);
    checkOutput("err_cleared", int'(bus.err), 0);
    checkOutput("num_12", int'(bus.number), 12);

    // A second start mid-conversion must be ignored.
    applyStimulus(4'd5, 4'd7);
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.tens  = 4'd1;
    bus.units = 4'd1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done) begin
        pulses = pulses + 1;
        checkOutput("num_57", int'(bus.number), 57);
      end
    end
    checkOutput("pulses_57", pulses, 1);

    // Reset between the fourth and fifth edges of a conversion.
    applyStimulus(4'd8, 4'd8);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("abort_busy",   int'(bus.busy),   0);
    checkOutput("abort_done",   int'(bus.done),   0);
    checkOutput("abort_number", int'(bus.number), 0);
    checkOutput("abort_err",    int'(bus.err),    0);
    @(negedge clk);
    #2 rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done) pulses = pulses + 1;
    end
    checkOutput("abort_pulses", pulses, 0);
    checkOutput("abort_num_held", int'(bus.number), 0);

    applyStimulus(4'd3, 4'd6);
    waitDone(cyc);
    checkOutput("post_rst_lat", cyc, 8);
    checkOutput("num_36", int'(bus.number), 36);

    // Back-to-back sweep: each start lands on the done cycle, so done spacing is 8 edges.
    for (int t = 0; t < 10; t++) begin
      for (int u = 0; u < 10; u++) begin
        applyStimulus(4'(t), 4'(u));
        waitDone(cyc);
        checkOutput("sweep_spacing", cyc, 8);
        checkOutput("sweep_number", int'(bus.number), 10 * t + u);
      end
    end

    @(negedge clk);
    checkEn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
